majority_bit_sampler: RTL and testbench
=======================================

// Module: majority_bit_sampler
// PURPOSE
//  UART RX oversampling front end. Takes a configurable, odd-sized window of
//  samples centred on mid-bit, majority-votes them, and reports the bit with a
//  one-cycle valid strobe and a noise flag (window not unanimous).
//  Sits between the RX edge/bit counter and the RX FSM / deserializer.
// PARAMETERS
//  PRESCALE_WIDTH  6  width of Prescale and edge_cnt
//  MAX_VOTES       7  largest window size; odd, 1..15
//  SYNC_STAGES     2  RX_IN synchronizer flops (0 = RX_IN used directly)
// PORTS
//  CLK          in   1                 RX oversampling clock
//  RST          in   1                 asynchronous, active-high reset
//  RX_IN        in   1                 serial line, idle high
//  samp_en      in   1                 sampling enable from RX FSM
//  edge_cnt     in   PRESCALE_WIDTH    oversample index within bit, 0..Prescale-1
//  Prescale     in   PRESCALE_WIDTH    oversamples per bit, >=2
//  vote_half    in   VOTE_W            half window h; N=2h+1 (VOTE_W=$clog2(MAX_VOTES/2+1))
//  sampled_bit  out  1                 majority result, held until next vote
//  bit_valid    out  1                 1-cycle strobe: new sampled_bit/noise_flag
//  noise_flag   out  1                 last window had disagreeing samples
// BEHAVIOUR
//  - Reset (async, RST=1): sync flops=1, accumulators=0, sampled_bit=1,
//    bit_valid=0, noise_flag=0. Release takes effect on next CLK edge.
//  - rx_s = RX_IN delayed SYNC_STAGES cycles (direct wire if 0).
//  - center = Prescale>>1 (odd Prescale rounds down).
//  - h_eff = min(vote_half, (MAX_VOTES-1)/2, center-1); center=0 -> h_eff=0.
//    N_eff = 2*h_eff+1. All clamping combinational, evaluated every cycle.
//  - Window: edge_cnt in [center-h_eff, center+h_eff]. Each cycle with
//    samp_en=1 and edge_cnt in window: ones_acc += rx_s, seen_acc += 1.
//  - Final sample (edge_cnt==center+h_eff, samp_en=1): tot=ones_acc+rx_s;
//    next edge: sampled_bit<=(tot>h_eff), noise_flag<=(tot!=0 && tot!=N_eff),
//    bit_valid<=1; accumulators cleared. Latency: 1 CLK after last sample.
//  - Vote only fires if seen_acc==2*h_eff at the final sample (complete window);
//    otherwise no bit_valid, outputs hold, accumulators clear.
//  - Accumulators clear when samp_en=0 or edge_cnt==0 (start of bit, unless
//    window starts at 0, i.e. center=0). samp_en drop mid-window aborts vote.
//  - bit_valid is high exactly one cycle per vote, else 0. sampled_bit and
//    noise_flag change only on a vote.
//  - Prescale/vote_half changed mid-bit: new h_eff used immediately; incomplete
//    window is discarded by the seen_acc check. No X, no wrap.
//  - Accumulator width $clog2(MAX_VOTES+1); cannot overflow (<=N_eff).
//  - Reset mid-window: everything returns to reset values at once; no strobe.
// TESTING (SYNC_STAGES=0 unless noted)
//  1. Prescale=8,h=1: rx_s=1,0,1 at edge_cnt 3,4,5 -> cycle after edge 5:
//     bit_valid=1, sampled_bit=1, noise_flag=1.
//  2. Prescale=16,h=2: rx_s=0 at edge_cnt 6..10 -> sampled_bit=0,
//     noise_flag=0, one bit_valid pulse per bit over 10 back-to-back bits.
//  3. Clamp: Prescale=4,vote_half=3 -> h_eff=1, samples at 1,2,3;
//     pattern 0,0,1 -> sampled_bit=0, noise_flag=1.
//  4. Prescale=16,h=3: samp_en low at edge_cnt 7 -> no bit_valid that bit;
//     sampled_bit/noise_flag unchanged; next full bit votes normally.
//  5. RST pulsed at edge_cnt 9 of Prescale=16 bit -> sampled_bit=1, bit_valid=0
//     immediately, no vote that bit; clean vote on following bit.
//  6. SYNC_STAGES=2, Prescale=8,h=0: 1->0 step on RX_IN -> sampled_bit follows
//     with edge alignment shifted by exactly 2 CLK; random h/Prescale sweep
//     vs. reference model, majority and noise_flag always match.

Source files
------------

// File: rtl/majority_bit_sampler.sv
// majority_bit_sampler: UART RX mid-bit majority vote over an odd oversample window with noise flag
module majority_bit_sampler #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int MAX_VOTES = 7,
  parameter int SYNC_STAGES = 2,
  localparam int VOTE_W = (MAX_VOTES > 2) ? $clog2(MAX_VOTES / 2 + 1) : 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      samp_en,
  input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic [VOTE_W-1:0]         vote_half,
  output logic                      sampled_bit,
  output logic                      bit_valid,
  output logic                      noise_flag
);
  localparam int W = PRESCALE_WIDTH;
  localparam int ACC_W = $clog2(MAX_VOTES + 1);
  localparam int HMAX = (MAX_VOTES - 1) / 2;
  logic rx_s;
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign rx_s = RX_IN;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync;
      always_ff @(posedge CLK or posedge RST)
        if (RST) sync <= '1;
        else begin
          sync[0] <= RX_IN;
          for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
        end
      assign rx_s = sync[SYNC_STAGES-1];
    end
  endgenerate
  logic [W-1:0] center, h_cap, vh, h_lim, h_eff, lo, hi;
  logic [ACC_W-1:0] ones, seen, need;
  logic [ACC_W:0] tot, n_eff, h_ext;
  logic in_win, last, clr;
  always_comb begin
    center = Prescale >> 1;
    h_cap = (center == '0) ? '0 : center - W'(1);
    vh = W'(vote_half);
    h_lim = (vh > W'(HMAX)) ? W'(HMAX) : vh;
    h_eff = (h_lim > h_cap) ? h_cap : h_lim;
    lo = center - h_eff;
    hi = center + h_eff;
    in_win = (edge_cnt >= lo) && (edge_cnt <= hi);
    last = samp_en && (edge_cnt == hi);
    clr = !samp_en || (edge_cnt == '0);
    need = ACC_W'({h_eff, 1'b0});
    tot = {1'b0, ones} + (ACC_W + 1)'(rx_s);
    n_eff = (ACC_W + 1)'({h_eff, 1'b1});
    h_ext = (ACC_W + 1)'(h_eff);
  end
  // seen saturates so a stalled edge_cnt can never wrap it into a false "complete"
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ones <= '0;
      seen <= '0;
      sampled_bit <= 1'b1;
      bit_valid <= 1'b0;
      noise_flag <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      if (last) begin
        if (seen == need) begin
          bit_valid <= 1'b1;
          sampled_bit <= tot > h_ext;
          noise_flag <= (tot != '0) && (tot != n_eff);
        end
        ones <= '0;
        seen <= '0;
      end else if (clr) begin
        ones <= '0;
        seen <= '0;
      end else if (in_win && seen != '1) begin
        ones <= ones + ACC_W'(rx_s);
        seen <= seen + ACC_W'(1);
      end
    end
endmodule

// File: tb/tb_majority_bit_sampler.sv
// tb_majority_bit_sampler: table vectors, directed corner sequences and a random sweep vs a window-count model
module tb_majority_bit_sampler;
  logic CLK = 1'b0, RST = 1'b0, RX_IN = 1'b1, samp_en = 1'b0;
  logic [5:0] edge_cnt = '0, Prescale = 6'd8;
  logic [1:0] vote_half = '0;
  logic sb0, bv0, nf0, sb2, bv2, nf2;
  int checks = 0, errors = 0;
  logic [63:0] s0, s2;
  bit rx_log[$];
  int np0, np2, pe0, pe2;
  logic b0, n0, b2, n2;

  majority_bit_sampler #(.PRESCALE_WIDTH(6), .MAX_VOTES(7), .SYNC_STAGES(0)) dut0 (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .samp_en(samp_en), .edge_cnt(edge_cnt),
    .Prescale(Prescale), .vote_half(vote_half), .sampled_bit(sb0), .bit_valid(bv0), .noise_flag(nf0));
  majority_bit_sampler #(.PRESCALE_WIDTH(6), .MAX_VOTES(7), .SYNC_STAGES(2)) dut2 (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .samp_en(samp_en), .edge_cnt(edge_cnt),
    .Prescale(Prescale), .vote_half(vote_half), .sampled_bit(sb2), .bit_valid(bv2), .noise_flag(nf2));

  always #5 CLK = ~CLK;

  typedef struct {
    int p;
    int vh;
    logic [63:0] pat;
    logic [63:0] en;
    int pulses;
    logic b;
    logic n;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // one bit period; rx_log mirrors the 2-flop synchronizer delay for dut2
  task automatic run_bit(input int p, input int vh, input logic [63:0] pat, input logic [63:0] en);
    np0 = 0; np2 = 0; pe0 = -1; pe2 = -1;
    Prescale = 6'(p);
    vote_half = 2'(vh);
    for (int e = 0; e < p; e++) begin
      edge_cnt = 6'(e);
      samp_en = en[e];
      RX_IN = pat[e];
      s0[e] = pat[e];
      rx_log.push_back(pat[e]);
      s2[e] = rx_log[rx_log.size() - 3];
      if (rx_log.size() > 8) void'(rx_log.pop_front());
      step();
      if (bv0) begin np0++; pe0 = e; b0 = sb0; n0 = nf0; end
      if (bv2) begin np2++; pe2 = e; b2 = sb2; n2 = nf2; end
    end
  endtask

  function automatic void ref_vote(input int p, input int vh, input logic [63:0] s,
                                   output int hi, output logic b, output logic n);
    int c = p / 2;
    int h = vh;
    int ones = 0;
    if (h > 3) h = 3;
    if (h > c - 1) h = c - 1;
    if (h < 0) h = 0;
    for (int e = c - h; e <= c + h; e++) ones += int'(s[e]);
    hi = c + h;
    b = (2 * ones) > (2 * h + 1);
    n = (ones != 0) && (ones != 2 * h + 1);
  endfunction

  initial begin
    int hi;
    logic eb, en_;
    int total;
    tbl[0]  = '{8,  1, 64'h28,    '1, 1, 1'b1, 1'b1};
    tbl[1]  = '{16, 2, 64'hF83F,  '1, 1, 1'b0, 1'b0};
    tbl[2]  = '{4,  3, 64'h8,     '1, 1, 1'b0, 1'b1};
    tbl[3]  = '{16, 3, 64'h0,     64'hFFFF_FFFF_FFFF_FF7F, 0, 1'b0, 1'b1};
    tbl[4]  = '{16, 3, 64'hFFFF,  '1, 1, 1'b1, 1'b0};
    tbl[5]  = '{2,  1, 64'h0,     '1, 1, 1'b0, 1'b0};
    tbl[6]  = '{3,  2, 64'h2,     '1, 1, 1'b1, 1'b0};
    tbl[7]  = '{16, 3, 64'hE0,    '1, 1, 1'b0, 1'b1};
    tbl[8]  = '{16, 3, 64'h1E0,   '1, 1, 1'b1, 1'b1};
    tbl[9]  = '{32, 3, 64'hFC000, '1, 1, 1'b1, 1'b1};
    tbl[10] = '{7,  3, 64'h6,     '1, 1, 1'b0, 1'b1};
    tbl[11] = '{8,  1, 64'hFF,    '0, 0, 1'b0, 1'b1};
    #2 RST = 1'b1;
    #1;
    chk("reset_bit", int'(sb0), 1);
    chk("reset_valid", int'(bv0), 0);
    chk("reset_noise", int'(nf0), 0);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    rx_log = {1'b1, 1'b1};
    for (int i = 0; i < 12; i++) begin
      run_bit(tbl[i].p, tbl[i].vh, tbl[i].pat, tbl[i].en);
      chk($sformatf("tbl%0d_pulses", i), np0, tbl[i].pulses);
      chk($sformatf("tbl%0d_bit", i), int'(tbl[i].pulses != 0 ? b0 : sb0), int'(tbl[i].b));
      chk($sformatf("tbl%0d_noise", i), int'(tbl[i].pulses != 0 ? n0 : nf0), int'(tbl[i].n));
    end
    // reset in the middle of a window: immediate return to idle values, no vote
    Prescale = 6'd16; vote_half = 2'd3; np0 = 0;
    for (int e = 0; e < 16; e++) begin
      edge_cnt = 6'(e); samp_en = 1'b1; RX_IN = 1'b0;
      if (e == 9) begin
        RST = 1'b1;
        #1;
        chk("midrst_bit", int'(sb0), 1);
        chk("midrst_valid", int'(bv0), 0);
        chk("midrst_noise", int'(nf0), 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        rx_log = {1'b1, 1'b1};
      end else begin
        rx_log.push_back(1'b0);
        step();
        if (bv0) np0++;
      end
    end
    chk("midrst_no_vote", np0, 0);
    run_bit(16, 3, 64'h0, '1);
    chk("after_rst_pulses", np0, 1);
    chk("after_rst_bit", int'(b0), 0);
    chk("after_rst_noise", int'(n0), 0);
    total = 0;
    for (int i = 0; i < 10; i++) begin
      run_bit(16, 2, 64'hF83F, '1);
      total += np0;
      chk($sformatf("b2b%0d_bit", i), int'(b0), 0);
    end
    chk("b2b_total_pulses", total, 10);
    // synchronizer alignment: dut2 samples RX_IN from exactly two cycles earlier
    run_bit(8, 0, 64'hF0, '1);
    run_bit(8, 0, 64'h07, '1);
    chk("sync_a_dut0_bit", int'(b0), 0);
    chk("sync_a_dut2_bit", int'(b2), 1);
    chk("sync_a_dut2_pulses", np2, 1);
    run_bit(8, 0, 64'h03, '1);
    chk("sync_b_dut2_bit", int'(b2), 0);
    for (int i = 0; i < 40; i++) begin
      int p = $urandom_range(2, 40);
      int vh = $urandom_range(0, 3);
      run_bit(p, vh, {$urandom(), $urandom()}, '1);
      ref_vote(p, vh, s0, hi, eb, en_);
      chk($sformatf("rnd%0d_d0_pulses", i), np0, 1);
      chk($sformatf("rnd%0d_d0_edge", i), pe0, hi);
      chk($sformatf("rnd%0d_d0_bit", i), int'(b0), int'(eb));
      chk($sformatf("rnd%0d_d0_noise", i), int'(n0), int'(en_));
      ref_vote(p, vh, s2, hi, eb, en_);
      chk($sformatf("rnd%0d_d2_pulses", i), np2, 1);
      chk($sformatf("rnd%0d_d2_edge", i), pe2, hi);
      chk($sformatf("rnd%0d_d2_bit", i), int'(b2), int'(eb));
      chk($sformatf("rnd%0d_d2_noise", i), int'(n2), int'(en_));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
